// File: rtl/eth_mdio_ctrl.sv
// eth_mdio_ctrl -- Clause 22 MDIO management master.
//
// Generates MDC from clk_i and shifts one PHY register read or write frame
// per accepted request. Read data comes back with a single-cycle response.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   req_*              valid/ready request channel (write flag, PHY/reg
//                      address, write data); fields latched on transfer
//   rsp_valid_o        one-cycle pulse at frame completion
//   rsp_rdata_o        read data (0 for writes), held until next response
//   busy_o             frame in progress
//   mdc_o              management clock
//   mdio_o/mdio_oe_o   MDIO output data / output enable
//   mdio_i             MDIO input (sampled on rising MDC during read data)
module eth_mdio_ctrl #(
  parameter int CLK_DIV      = 50,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [4:0]  req_phy_addr_i,
  input  logic [4:0]  req_reg_addr_i,
  input  logic [15:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_rdata_o,
  output logic        busy_o,
  output logic        mdc_o,
  output logic        mdio_o,
  output logic        mdio_oe_o,
  input  logic        mdio_i
);

  localparam logic [9:0] DIV_LAST     = 10'(CLK_DIV - 1);
  // Response is registered, so it is armed one cycle before the final cycle.
  localparam logic [9:0] DIV_PRE_LAST = 10'(CLK_DIV - 2);
  localparam bit         HAS_PRE      = (PREAMBLE_LEN > 0);
  localparam logic [5:0] PRE_LAST     = HAS_PRE ? 6'(PREAMBLE_LEN - 1) : 6'd0;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_END
  } state_t;

  state_t      state, state_next;
  logic [9:0]  div_cnt;
  logic [5:0]  bit_cnt;
  logic        mdc;
  logic        op_write;
  logic [31:0] tx_shift;   // ST, OP, PHYAD, REGAD, TA, DATA
  logic [15:0] rx_shift;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;

  logic accept, half_end, bit_end, last_bit;

  assign accept   = req_valid_i & (state == S_IDLE);
  assign half_end = (div_cnt == DIV_LAST);
  // A bit period ends at the terminal count of its high half (falling MDC).
  assign bit_end  = (state != S_IDLE) & mdc & half_end;

  always_comb begin
    last_bit = 1'b0;
    case (state)
      S_PRE:   last_bit = (bit_cnt == PRE_LAST);
      S_HDR:   last_bit = (bit_cnt == 6'd13);
      S_TA:    last_bit = (bit_cnt == 6'd1);
      S_DATA:  last_bit = (bit_cnt == 6'd15);
      S_END:   last_bit = 1'b1;
      default: last_bit = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = HAS_PRE ? S_PRE : S_HDR;
      S_PRE:  if (bit_end && last_bit) state_next = S_HDR;
      S_HDR:  if (bit_end && last_bit) state_next = S_TA;
      S_TA:   if (bit_end && last_bit) state_next = S_DATA;
      S_DATA: if (bit_end && last_bit) state_next = S_END;
      S_END:  if (bit_end) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Bit timing, shift registers and response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      mdc       <= 1'b0;
      op_write  <= 1'b0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        div_cnt  <= '0;
        bit_cnt  <= '0;
        mdc      <= 1'b0;
        op_write <= req_write_i;
        tx_shift <= {2'b01, (req_write_i ? 2'b01 : 2'b10), req_phy_addr_i,
                     req_reg_addr_i, 2'b10,
                     (req_write_i ? req_wdata_i : 16'h0000)};
        rx_shift <= '0;
      end else if (state != S_IDLE) begin
        div_cnt <= half_end ? 10'd0 : div_cnt + 10'd1;
        // Toggling at the end of END's high half leaves MDC low in IDLE.
        if (half_end) mdc <= ~mdc;
        if (bit_end) begin
          bit_cnt <= last_bit ? 6'd0 : bit_cnt + 6'd1;
          if (state == S_HDR || state == S_TA || state == S_DATA)
            tx_shift <= {tx_shift[30:0], 1'b0};
        end
        // Sample in the first cycle of the MDC high half.
        if (state == S_DATA && !op_write && mdc && div_cnt == 10'd0)
          rx_shift <= {rx_shift[14:0], mdio_i};
        if (state == S_END && mdc && div_cnt == DIV_PRE_LAST) begin
          rsp_valid <= 1'b1;
          rsp_rdata <= op_write ? 16'h0000 : rx_shift;
        end
      end
    end
  end

  // Outputs. MDIO depends only on state/tx_shift, which change solely at
  // bit-period boundaries, so MDIO moves only with falling MDC.
  always_comb begin
    busy_o    = (state != S_IDLE);
    mdio_oe_o = 1'b0;
    mdio_o    = 1'b1;
    case (state)
      S_PRE: begin
        mdio_oe_o = 1'b1;
        mdio_o    = 1'b1;
      end
      S_HDR: begin
        mdio_oe_o = 1'b1;
        mdio_o    = tx_shift[31];
      end
      S_TA, S_DATA: begin
        mdio_oe_o = op_write;
        mdio_o    = op_write ? tx_shift[31] : 1'b1;
      end
      default: begin
        mdio_oe_o = 1'b0;
        mdio_o    = 1'b1;
      end
    endcase
  end

  assign req_ready_o = ~busy_o;
  assign mdc_o       = mdc;
  assign rsp_valid_o = rsp_valid;
  assign rsp_rdata_o = rsp_rdata;

endmodule

// File: tb/tb_eth_mdio_ctrl.sv
// Testbench for eth_mdio_ctrl: two instances (CLK_DIV=4/PREAMBLE_LEN=32 and
// CLK_DIV=2/PREAMBLE_LEN=0). Stimulus pushes expected responses into
// per-instance queues; monitors pop and compare on rsp_valid_o.
module tb_eth_mdio_ctrl;

  localparam int LAT1 = 520;  // 2*4*(32+33)
  localparam int LAT2 = 132;  // 2*2*(0+33)

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 1
  logic        rst1, v1, w1, rdy1, rv1, busy1, mdc1, mo1, moe1, mi1;
  logic [4:0]  pa1, ra1;
  logic [15:0] wd1, rd1;
  // Instance 2
  logic        rst2, v2, w2, rdy2, rv2, busy2, mdc2, mo2, moe2, mi2;
  logic [4:0]  pa2, ra2;
  logic [15:0] wd2, rd2;

  eth_mdio_ctrl #(.CLK_DIV(4), .PREAMBLE_LEN(32)) dut1 (
    .clk_i(clk), .rst_i(rst1), .req_valid_i(v1), .req_ready_o(rdy1),
    .req_write_i(w1), .req_phy_addr_i(pa1), .req_reg_addr_i(ra1),
    .req_wdata_i(wd1), .rsp_valid_o(rv1), .rsp_rdata_o(rd1), .busy_o(busy1),
    .mdc_o(mdc1), .mdio_o(mo1), .mdio_oe_o(moe1), .mdio_i(mi1)
  );

  eth_mdio_ctrl #(.CLK_DIV(2), .PREAMBLE_LEN(0)) dut2 (
    .clk_i(clk), .rst_i(rst2), .req_valid_i(v2), .req_ready_o(rdy2),
    .req_write_i(w2), .req_phy_addr_i(pa2), .req_reg_addr_i(ra2),
    .req_wdata_i(wd2), .rsp_valid_o(rv2), .rsp_rdata_o(rd2), .busy_o(busy2),
    .mdc_o(mdc2), .mdio_o(mo2), .mdio_oe_o(moe2), .mdio_i(mi2)
  );

  typedef struct {
    logic [15:0] data;
    int          t;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- instance 1: capture, PHY model, response monitor -----
  logic [64:0] cap1_mdio, cap1_oe;
  int          ncap1 = 0;
  logic [15:0] phy_data1 = 16'h0000;

  initial begin
    logic mdc_last, busy_last;
    exp_t e;
    mdc_last  = 1'b0;
    busy_last = 1'b0;
    cap1_mdio = '0;
    cap1_oe   = '0;
    forever begin
      @(negedge clk);
      if (busy1 && !busy_last) begin
        ncap1     = 0;
        cap1_mdio = '0;
        cap1_oe   = '0;
      end
      if (mdc1 && !mdc_last) begin
        cap1_mdio = {cap1_mdio[63:0], mo1};
        cap1_oe   = {cap1_oe[63:0], moe1};
        ncap1++;
      end
      // PHY drives read data on the falling MDC edge that starts bit ncap1.
      if (!mdc1 && mdc_last) begin
        if (ncap1 >= 48 && ncap1 <= 63) mi1 = phy_data1[63 - ncap1];
        else                            mi1 = 1'b1;
      end
      if (!rst1 && rv1) begin
        if (q1.size() == 0) begin
          check("rsp1_unexpected", 1'b1, 1'b0);
        end else begin
          e = q1.pop_front();
          check("rsp1_rdata", rd1, e.data);
          check("rsp1_cycle", cyc, e.t);
        end
      end
      mdc_last  = mdc1;
      busy_last = busy1;
    end
  end

  // ---------------- instance 2: capture, timing assertions, monitor -------
  logic [32:0] cap2_mdio;
  int          ncap2 = 0;

  initial begin
    logic mdc_last, busy_last, mo_last, moe_last;
    int   last_rise;
    exp_t e;
    mdc_last  = 1'b0;
    busy_last = 1'b0;
    mo_last   = 1'b1;
    moe_last  = 1'b0;
    last_rise = -1;
    cap2_mdio = '0;
    forever begin
      @(negedge clk);
      if (!rst2) begin
        if (busy2 && !busy_last) begin
          ncap2     = 0;
          cap2_mdio = '0;
          last_rise = -1;
        end
        if (mdc2 && !mdc_last) begin
          if (busy2 && last_rise >= 0) check("mdc2_period", cyc - last_rise, 4);
          last_rise = cyc;
          cap2_mdio = {cap2_mdio[31:0], mo2};
          ncap2++;
        end
        if (!busy2) last_rise = -1;
        // MDIO may change only at a bit-period start: falling MDC or frame start.
        if (mo2 !== mo_last || moe2 !== moe_last)
          check("mdio2_edge_align", (!mdc2 && mdc_last) || (busy2 && !busy_last), 1'b1);
        if (rv2) begin
          if (q2.size() == 0) begin
            check("rsp2_unexpected", 1'b1, 1'b0);
          end else begin
            e = q2.pop_front();
            check("rsp2_rdata", rd2, e.data);
            check("rsp2_cycle", cyc, e.t);
          end
        end
      end
      mdc_last  = mdc2;
      busy_last = busy2;
      mo_last   = mo2;
      moe_last  = moe2;
    end
  end

  // ---------------- stimulus tasks ---------------------------------------
  task automatic issue1(input logic w, input logic [4:0] pa, input logic [4:0] ra,
                        input logic [15:0] wd, input logic [15:0] exp, output int acc);
    int n = 0;
    @(negedge clk);
    v1 = 1'b1; w1 = w; pa1 = pa; ra1 = ra; wd1 = wd;
    while (!rdy1 && n < 2000) begin @(negedge clk); n++; end
    check("issue1_ready", rdy1, 1'b1);
    acc = cyc;
    q1.push_back('{data: exp, t: acc + LAT1});
    @(negedge clk);
    v1 = 1'b0;
  endtask

  task automatic issue2(input logic w, input logic [4:0] pa, input logic [4:0] ra,
                        input logic [15:0] wd, input logic [15:0] exp, output int acc);
    int n = 0;
    @(negedge clk);
    v2 = 1'b1; w2 = w; pa2 = pa; ra2 = ra; wd2 = wd;
    while (!rdy2 && n < 2000) begin @(negedge clk); n++; end
    check("issue2_ready", rdy2, 1'b1);
    acc = cyc;
    q2.push_back('{data: exp, t: acc + LAT2});
    @(negedge clk);
    v2 = 1'b0;
  endtask

  task automatic drain1(input int max);
    int n = 0;
    while ((q1.size() != 0 || busy1) && n < max) begin @(negedge clk); n++; end
    check("drain1_done", (q1.size() == 0) && !busy1, 1'b1);
  endtask

  task automatic drain2(input int max);
    int n = 0;
    while ((q2.size() != 0 || busy2) && n < max) begin @(negedge clk); n++; end
    check("drain2_done", (q2.size() == 0) && !busy2, 1'b1);
  endtask

  // ---------------- main sequence -----------------------------------------
  initial begin
    int a, n;
    rst1 = 1'b1; v1 = 1'b0; w1 = 1'b0; pa1 = '0; ra1 = '0; wd1 = '0; mi1 = 1'b1;
    rst2 = 1'b1; v2 = 1'b0; w2 = 1'b0; pa2 = '0; ra2 = '0; wd2 = '0; mi2 = 1'b1;
    repeat (3) @(negedge clk);
    rst1 = 1'b0;
    rst2 = 1'b0;
    @(negedge clk);
    check("rst_ready",  rdy1,  1'b1);
    check("rst_rvalid", rv1,   1'b0);
    check("rst_rdata",  rd1,   16'h0000);
    check("rst_busy",   busy1, 1'b0);
    check("rst_mdc",    mdc1,  1'b0);
    check("rst_mdio",   mo1,   1'b1);
    check("rst_oe",     moe1,  1'b0);

    // Write 0x1140 to PHY 1 reg 0
    issue1(1'b1, 5'h01, 5'h00, 16'h1140, 16'h0000, a);
    drain1(700);
    check("wr_nbits", ncap1, 65);
    check("wr_mdio", cap1_mdio,
          {32'hFFFF_FFFF, 2'b01, 2'b01, 5'b00001, 5'b00000, 2'b10, 16'h1140, 1'b1});
    check("wr_oe", cap1_oe, {{64{1'b1}}, 1'b0});

    // Read PHY 3 reg 2, PHY returns 0x0141
    phy_data1 = 16'h0141;
    issue1(1'b0, 5'h03, 5'h02, 16'h0000, 16'h0141, a);
    drain1(700);
    check("rd_hdr", cap1_mdio[64:19],
          {32'hFFFF_FFFF, 2'b01, 2'b10, 5'b00011, 5'b00010});
    check("rd_oe", cap1_oe, {{46{1'b1}}, {19{1'b0}}});

    // Back-to-back: valid held high with two different requests
    @(negedge clk);
    v1 = 1'b1; w1 = 1'b1; pa1 = 5'h05; ra1 = 5'h04; wd1 = 16'hBEEF;
    check("b2b_first_ready", rdy1, 1'b1);
    a = cyc;
    q1.push_back('{data: 16'h0000, t: a + LAT1});
    q1.push_back('{data: 16'hA5C3, t: a + LAT1 + 1 + LAT1});
    @(negedge clk);
    w1 = 1'b0; pa1 = 5'h03; ra1 = 5'h02; wd1 = 16'h1234;
    phy_data1 = 16'hA5C3;
    n = 0;
    while (!rdy1 && n < 700) begin @(negedge clk); n++; end
    check("b2b_ready_rise", cyc, a + LAT1 + 1);
    @(negedge clk);
    v1 = 1'b0;
    drain1(700);

    // Reset in the 10th data bit of a read
    phy_data1 = 16'h0141;
    issue1(1'b0, 5'h03, 5'h02, 16'h0000, 16'h0141, a);
    while (cyc < a + 460) @(negedge clk);
    rst1 = 1'b1;
    q1.delete();
    @(negedge clk);
    check("abort_mdc",   mdc1,  1'b0);
    check("abort_oe",    moe1,  1'b0);
    check("abort_busy",  busy1, 1'b0);
    check("abort_ready", rdy1,  1'b1);
    check("abort_mdio",  mo1,   1'b1);
    check("abort_rdata", rd1,   16'h0000);
    rst1 = 1'b0;
    repeat (100) @(negedge clk);
    issue1(1'b1, 5'h01, 5'h1F, 16'h0000, 16'h0000, a);
    drain1(700);
    check("post_abort_nbits", ncap1, 65);

    // No preamble, CLK_DIV=2 read; bus idles high so data reads 0xFFFF
    mi2 = 1'b1;
    issue2(1'b0, 5'h01, 5'h01, 16'h0000, 16'hFFFF, a);
    drain2(300);
    check("p0_nbits", ncap2, 33);
    check("p0_st_op", cap2_mdio[32:29], 4'b0110);

    // CLK_DIV=2 continuous: three writes with valid held high
    @(negedge clk);
    v2 = 1'b1; w2 = 1'b1; pa2 = 5'h02; ra2 = 5'h10; wd2 = 16'h0001;
    check("cont_first_ready", rdy2, 1'b1);
    a = cyc;
    q2.push_back('{data: 16'h0000, t: a + LAT2});
    q2.push_back('{data: 16'h0000, t: a + (LAT2 + 1) + LAT2});
    q2.push_back('{data: 16'h0000, t: a + 2 * (LAT2 + 1) + LAT2});
    @(negedge clk);
    wd2 = 16'h8000;
    n = 0;
    while (!rdy2 && n < 300) begin @(negedge clk); n++; end
    check("cont_ready2", cyc, a + LAT2 + 1);
    @(negedge clk);
    wd2 = 16'h5A5A;
    n = 0;
    while (!rdy2 && n < 300) begin @(negedge clk); n++; end
    check("cont_ready3", cyc, a + 2 * (LAT2 + 1));
    @(negedge clk);
    v2 = 1'b0;
    drain2(300);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
